conv_encoder_framer: RTL

//  Rate-1/2 feed-forward convolutional encoder with frame control, directly upstream of

---
 rtl/conv_encoder_framer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/conv_encoder_framer.sv
`default_nettype none
// ============================================================================
// Module   : conv_encoder_framer
// Brief    : Rate-1/2 feed-forward convolutional encoder with SOF/EOF framing
//            and zero-tail trellis termination, paced at one symbol per tick.
// Revision : 1.0 - initial release
// ============================================================================
module conv_encoder_framer #(
    parameter int             K          = 3,
    parameter logic [K-1:0]   G0         = 3'b111,
    parameter logic [K-1:0]   G1         = 3'b101,
    parameter int             SYM_CYCLES = 4
) (
    input  logic       clk_sig,
    input  logic       reset_sig,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic       in_eof,
    output logic       in_ready,
    output logic [1:0] code_sig,
    output logic       code_valid,
    output logic       frame_done,
    output logic       underrun
);

    localparam int CW = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
    localparam int TW = $clog2(K);

    localparam logic [CW-1:0] C_SYM_LAST  = CW'(SYM_CYCLES - 1);
    localparam logic [TW-1:0] C_TAIL_LEN  = TW'(K - 1);
    localparam logic [TW-1:0] C_TAIL_LAST = TW'(1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_DATA = 2'd1;
    localparam logic [1:0] C_TAIL = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [CW-1:0] r_sym_cnt;
    logic [K-2:0]  r_sr;
    logic [K-2:0]  w_sr_base;
    logic [K-2:0]  w_sr_next;
    logic [TW-1:0] r_tail_cnt;
    logic [TW-1:0] w_tail_next;
    logic [1:0]    r_code;
    logic [1:0]    w_code_next;
    logic          r_code_valid;
    logic          r_underrun;
    logic          w_underrun_next;
    logic          r_frame_done;
    logic          w_frame_done_next;
    logic          w_tick;
    logic          w_encode;
    logic          w_b;
    logic [K-1:0]  w_win;

    assign w_tick = (r_sym_cnt == C_SYM_LAST);

    // State and datapath registers; everything except the symbol counter and
    // the done pulse only moves on a tick.
    always_ff @(posedge clk_sig) begin
        if (!reset_sig) begin
            r_state      <= C_IDLE;
            r_sym_cnt    <= '0;
            r_sr         <= '0;
            r_tail_cnt   <= '0;
            r_code       <= 2'b00;
            r_code_valid <= 1'b0;
            r_underrun   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_sym_cnt    <= w_tick ? '0 : r_sym_cnt + 1'b1;
            r_frame_done <= w_frame_done_next;
            if (w_tick) begin
                r_state      <= w_state_next;
                r_sr         <= w_sr_next;
                r_tail_cnt   <= w_tail_next;
                r_code       <= w_code_next;
                r_code_valid <= w_encode;
                r_underrun   <= w_underrun_next;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_IDLE: begin
                if (in_valid && in_sof) begin
                    w_state_next = in_eof ? C_TAIL : C_DATA;
                end
            end
            C_DATA: begin
                if (in_valid && in_eof) begin
                    w_state_next = C_TAIL;
                end
            end
            C_TAIL: begin
                if (r_tail_cnt == C_TAIL_LAST) begin
                    w_state_next = C_IDLE;
                end
            end
            default: w_state_next = C_IDLE;
        endcase
    end

    always_comb begin
        w_encode          = 1'b0;
        w_b               = 1'b0;
        w_sr_base         = r_sr;
        w_tail_next       = r_tail_cnt;
        w_underrun_next   = r_underrun;
        w_frame_done_next = 1'b0;
        case (r_state)
            C_IDLE: begin
                // A new frame always starts from the all-zero trellis state.
                if (in_valid && in_sof) begin
                    w_encode    = 1'b1;
                    w_b         = in_bit;
                    w_sr_base   = '0;
                    w_tail_next = C_TAIL_LEN;
                end
            end
            C_DATA: begin
                if (in_valid) begin
                    w_encode = 1'b1;
                    w_b      = in_bit;
                    if (in_eof) begin
                        w_tail_next = C_TAIL_LEN;
                    end
                end else begin
                    w_underrun_next = 1'b1;
                end
            end
            C_TAIL: begin
                w_encode          = 1'b1;
                w_b               = 1'b0;
                w_tail_next       = r_tail_cnt - 1'b1;
                w_frame_done_next = w_tick && (r_tail_cnt == C_TAIL_LAST);
            end
            default: ;
        endcase
        w_win       = {w_b, w_sr_base};
        w_code_next = w_encode ? {^(w_win & G0), ^(w_win & G1)} : 2'b00;
    end

    generate
        if (K == 2) begin : g_sr_single
            always_comb w_sr_next = w_encode ? w_b : r_sr;
        end else begin : g_sr_multi
            always_comb w_sr_next = w_encode ? {w_b, w_sr_base[K-2:1]} : r_sr;
        end
    endgenerate

    assign in_ready   = w_tick && ((r_state == C_IDLE) || (r_state == C_DATA));
    assign code_sig   = r_code;
    assign code_valid = r_code_valid;
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire
